updown_pulse_gen: RTL and testbench
===================================

// Module: updown_pulse_gen
// PURPOSE
//   Upstream stage of the up/down Counter. Conditions two raw asynchronous push-button
//   inputs: 2-FF synchronizer, per-channel debounce FSM, edge-to-pulse conversion.
//   Emits single-cycle, mutually exclusive up/down pulses that drive the Counter's
//   up/down inputs directly. One press produces exactly one count step, or a
//   repeat train of steps when REPEAT_EN is defined.
// PARAMETERS
//   DB_CYCLES     16   consecutive stable synced samples required to accept a level change (>=2)
//   DB_W          5    debounce counter width; 2**DB_W > DB_CYCLES
//   REPEAT_DELAY  64   cycles from first pulse to first repeat pulse (REPEAT_EN only)
//   REPEAT_PERIOD 16   cycles between subsequent repeat pulses (REPEAT_EN only, >=2)
//   RPT_W         7    repeat timer width; 2**RPT_W > max(REPEAT_DELAY,REPEAT_PERIOD)
// PORTS
//   clk           in   1  system clock, all flops on rising edge
//   arstn         in   1  asynchronous active-low reset
//   btn_up_raw    in   1  raw up button, asynchronous, active-high, may bounce
//   btn_down_raw  in   1  raw down button, asynchronous, active-high, may bounce
//   up            out  1  one-cycle increment pulse to Counter.up (registered)
//   down          out  1  one-cycle decrement pulse to Counter.down (registered)
//   up_held       out  1  debounced up level (1 in PRESSED/DB_RELEASE)
//   down_held     out  1  debounced down level
// BEHAVIOUR
//   - Reset (arstn=0, async): sync flops, counters=0, FSMs=IDLE, all outputs 0.
//     Reset mid-press discards the press; after release of reset, a still-held button
//     is re-debounced from IDLE and produces a fresh pulse.
//   - Sync: 2 flops per channel; FSM sees s = sync stage 2 only.
//   - Per-channel FSM (identical for up and down):
//     IDLE:       s=1 -> DB_PRESS, cnt<=1; else stay.
//     DB_PRESS:   s=0 -> IDLE, cnt<=0. s=1 and cnt==DB_CYCLES-1 -> PRESSED, raw pulse
//                 request; else cnt<=cnt+1.
//     PRESSED:    s=0 -> DB_RELEASE, cnt<=1; else stay.
//     DB_RELEASE: s=1 -> PRESSED, cnt<=0, no new pulse. s=0 and cnt==DB_CYCLES-1 ->
//                 IDLE; else cnt<=cnt+1.
//   - Latency: raw rise first sampled at edge N and held stable -> pulse high for
//     exactly the one cycle following edge N+1+DB_CYCLES.
//   - Glitches shorter than DB_CYCLES synced cycles produce no pulse and no held change.
//   - Arbitration: if both channels request a pulse in the same cycle, both are
//     dropped (up=down=0). up&down is never 1. Held outputs are not arbitrated.
//   - No count saturation here; wrap handling is the Counter's responsibility.
// CONFIGURATION
//   UPDOWN_REPEAT_EN defined: per-channel RPT_W timer cleared on entry to PRESSED.
//     While the channel stays PRESSED or DB_RELEASE, a repeat pulse is requested
//     REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
//     Return to IDLE clears the timer. Repeat pulses use the same arbitration.
//   UPDOWN_REPEAT_EN undefined: timers absent; exactly one pulse per accepted press,
//     regardless of hold duration.
// TESTING  (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//   1 Reset: arstn=0 with btn_up_raw=1 -> up=down=up_held=down_held=0; release reset ->
//     one up pulse after edge 5 from release.
//   2 Clean press: btn_up_raw 0->1 at edge 0, held 20 cycles -> up=1 only in the cycle
//     after edge 5, up_held=1 from edge 5; down stays 0.
//   3 Bounce: btn_down_raw toggles 1,0,1,1,0 (1-cycle segments) then stable 1 -> no pulse
//     during bounce; one down pulse 5 cycles after the stable run starts.
//   4 Release bounce: while PRESSED, 2-cycle low glitch -> no new pulse, up_held stays 1;
//     6-cycle low -> up_held falls, next press pulses again.
//   5 Simultaneous: both raw inputs rise at edge 0 -> up=down=0 always; both held=1.
//   6 Repeat (REPEAT_EN): hold up 30 cycles -> pulses at cycle P, P+8, P+11, P+14, ...
//     Without REPEAT_EN -> single pulse at P. Counter downstream increments by pulse count.

Source files
------------

// File: rtl/updown_pulse_gen.sv
// Up/down push-button conditioner: 2-FF sync, per-channel debounce FSM, arbitrated pulses.
// Define UPDOWN_REPEAT_EN to add auto-repeat pulse trains while a button stays held.
module updown_pulse_gen #(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned DB_W          = 5,
    parameter int unsigned REPEAT_DELAY  = 64,
    parameter int unsigned REPEAT_PERIOD = 16,
    parameter int unsigned RPT_W         = 7
) (
    input  logic clk,
    input  logic arstn,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic up_held,
    output logic down_held
);

    typedef enum logic [1:0] {StIdle, StDbPress, StPressed, StDbRelease} state_e;

    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || (2 ** DB_W) <= DB_CYCLES) begin : g_bad_db
        $error("updown_pulse_gen: DB_CYCLES must be >= 2 and fit in DB_W bits");
    end
    if (REPEAT_PERIOD < 2 || (2 ** RPT_W) <= REPEAT_DELAY || (2 ** RPT_W) <= REPEAT_PERIOD)
    begin : g_bad_rpt
        $error("updown_pulse_gen: repeat timing must be >= 2 and fit in RPT_W bits");
    end

    // Channel 0 is up, channel 1 is down.
    logic [1:0] raw;
    logic [1:0] req;
    logic [1:0] held;

    assign raw = {btn_down_raw, btn_up_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic            sync1_q, sync2_q;
        state_e          state_q, state_d;
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            press_done;
        logic            rpt_fire;
        logic            held_ch;

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw[ch];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (sync2_q) begin
                        state_d = StDbPress;
                        cnt_d   = DB_W'(1);
                    end
                end
                StDbPress: begin
                    if (!sync2_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DbLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                StPressed: begin
                    if (!sync2_q) begin
                        state_d = StDbRelease;
                        cnt_d   = DB_W'(1);
                    end
                end
                StDbRelease: begin
                    if (sync2_q) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == DbLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            press_done = (state_q == StDbPress) && sync2_q && (cnt_q == DbLast);
            held_ch    = (state_q == StPressed) || (state_q == StDbRelease);
        end

`ifdef UPDOWN_REPEAT_EN
        localparam logic [RPT_W-1:0] DelayLast  = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] PeriodLast = RPT_W'(REPEAT_PERIOD - 1);

        logic [RPT_W-1:0] tmr_q, tmr_d;
        logic             first_q, first_d;

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                tmr_q   <= '0;
                first_q <= 1'b1;
            end else begin
                tmr_q   <= tmr_d;
                first_q <= first_d;
            end
        end

        // first_q selects the initial delay; after the first repeat the shorter period applies.
        always_comb begin
            tmr_d    = tmr_q;
            first_d  = first_q;
            rpt_fire = 1'b0;
            if (press_done || !held_ch) begin
                tmr_d   = '0;
                first_d = 1'b1;
            end else if (tmr_q == (first_q ? DelayLast : PeriodLast)) begin
                rpt_fire = 1'b1;
                tmr_d    = '0;
                first_d  = 1'b0;
            end else begin
                tmr_d = tmr_q + RPT_W'(1);
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign req[ch]  = press_done | rpt_fire;
        assign held[ch] = held_ch;
    end

    // Coincident requests cancel so the counter never sees up and down together.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= req[0] & ~req[1];
            down <= req[1] & ~req[0];
        end
    end

    assign up_held   = held[0];
    assign down_held = held[1];

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Bench for updown_pulse_gen: per-cycle raw patterns with expected outputs, queued and
// checked one cycle at a time; extra hand-written sequence for asynchronous mid-press reset.
module tb_updown_pulse_gen;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic btn_up_raw = 1'b0;
    logic btn_down_raw = 1'b0;
    logic up, down, up_held, down_held;

    updown_pulse_gen #(
        .DB_CYCLES    (4),
        .DB_W         (3),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(3),
        .RPT_W        (4)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .up          (up),
        .down        (down),
        .up_held     (up_held),
        .down_held   (down_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          len;
        logic [63:0] up_raw;
        logic [63:0] dn_raw;
        logic [63:0] exp_up;
        logic [63:0] exp_dn;
        logic [63:0] exp_uh;
        logic [63:0] exp_dh;
    } vec_t;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    sb_t  mon_e;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] rng(int lo, int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bitm(int b);
        logic [63:0] m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input int cyc, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: {up,down,up_held,down_held} got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input int len, input logic [63:0] ur,
                           input logic [63:0] dr, input logic [63:0] eu, input logic [63:0] ed,
                           input logic [63:0] euh, input logic [63:0] edh);
        vec_t v;
        v.name = name; v.len = len; v.up_raw = ur; v.dn_raw = dr;
        v.exp_up = eu; v.exp_dn = ed; v.exp_uh = euh; v.exp_dh = edh;
        vecs.push_back(v);
    endtask

    // Reset with the first raw level already applied, release half a cycle before edge 0,
    // then drive bit k ahead of edge k and queue the outputs expected just after edge k.
    task automatic run_vec(input vec_t v);
        sb_t e;
        @(negedge clk);
        arstn        = 1'b0;
        btn_up_raw   = v.up_raw[0];
        btn_down_raw = v.dn_raw[0];
        repeat (2) @(negedge clk);
        check({v.name, "_reset"}, -1, {up, down, up_held, down_held}, 4'b0000);
        for (int k = 0; k < v.len; k++) begin
            if (k > 0) @(negedge clk);
            arstn        = 1'b1;
            btn_up_raw   = v.up_raw[k];
            btn_down_raw = v.dn_raw[k];
            e.name = v.name;
            e.cyc  = k;
            e.exp  = {v.exp_up[k], v.exp_dn[k], v.exp_uh[k], v.exp_dh[k]};
            sbq.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check(mon_e.name, mon_e.cyc, {up, down, up_held, down_held}, mon_e.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rep;
        add_vec("clean_up", 28, rng(0, 19), '0, bitm(5), '0, rng(5, 24), '0);
        add_vec("bounce_dn", 28, rng(5, 27) | bitm(0) | bitm(2) | bitm(3), '0 | 64'd0,
                '0, bitm(10), '0, rng(10, 27));
        // bounce_dn drives the down channel; swap fields after construction
        vecs[1].dn_raw = vecs[1].up_raw;
        vecs[1].up_raw = '0;
        add_vec("rel_glitch", 36, rng(0, 9) | rng(12, 19) | rng(26, 35), '0,
                bitm(5) | bitm(31), '0, rng(5, 24) | rng(31, 35), '0);
        add_vec("simultaneous", 28, rng(0, 19), rng(0, 19), '0, '0, rng(5, 24), rng(5, 24));
        add_vec("staggered", 30, rng(0, 15), rng(3, 20), bitm(5), bitm(8), rng(5, 20),
                rng(8, 25));
        add_vec("glitch3", 16, rng(2, 4), '0, '0, '0, '0, '0);
        add_vec("glitch4", 16, rng(2, 5), '0, bitm(7), '0, rng(7, 10), '0);
        add_vec("dn_glitch3", 16, '0, rng(2, 4), '0, '0, '0, '0);
`ifdef UPDOWN_REPEAT_EN
        rep = bitm(5);
        for (int p = 13; p <= 34; p += 3) rep[p] = 1'b1;
        add_vec("repeat_hold", 40, rng(0, 29), '0, rep, '0, rng(5, 34), '0);
`else
        rep = bitm(5);
        add_vec("single_hold", 40, rng(0, 29), '0, rep, '0, rng(5, 34), '0);
`endif
        add_vec("reset_held", 16, rng(0, 11), '0, bitm(5), '0, rng(5, 16), '0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a press, then re-debounce of the held button.
        @(negedge clk);
        arstn        = 1'b0;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        repeat (2) @(negedge clk);
        arstn      = 1'b1;
        btn_up_raw = 1'b1;
        repeat (8) @(negedge clk);
        check("midpress_held", 7, {up, down, up_held, down_held}, 4'b0010);
        #2;
        arstn = 1'b0;
        #1;
        check("midpress_async_rst", 7, {up, down, up_held, down_held}, 4'b0000);
        run_vec(vecs[vecs.size() - 1]);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
